// File: rtl/pc_exc_pkg.sv
// Shared next-PC select codes and default address constants for the PC/exception sequencer.
package pc_exc_pkg;

  localparam logic [2:0] PCSEL_PLUS4  = 3'd0;
  localparam logic [2:0] PCSEL_BRANCH = 3'd1;
  localparam logic [2:0] PCSEL_JUMP   = 3'd2;
  localparam logic [2:0] PCSEL_JR     = 3'd3;
  localparam logic [2:0] PCSEL_ERET   = 3'd4;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] DEF_VEC_BASE   = 32'h8000_0004;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'd8;

  // Branch/jump targets inherit the current privilege bit so they cannot enter or leave kernel mode.
  function automatic logic [31:0] keep_priv(input logic [31:0] tgt, input logic priv);
    return {priv, tgt[30:0]};
  endfunction

endpackage

// File: rtl/pc_exc_unit_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the lowest set index.
module irq_prio_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      valid_o = valid_o | req_i[i];
      idx_o   = req_i[i] ? IW'(i) : idx_o;
    end
  end

endmodule

// File: rtl/pc_exc_unit.sv
// Program counter with next-PC selection, edge-triggered masked interrupts, EPC and return-from-exception.
module pc_exc_unit
  import pc_exc_pkg::*;
#(
  parameter int          N_IRQ      = 4,
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
  parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE,
  localparam int         CW         = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStall,
  input  logic [2:0]       iPCSel,
  input  logic [31:0]      iBranchTgt,
  input  logic [31:0]      iJumpTgt,
  input  logic [31:0]      iJRTgt,
  input  logic [N_IRQ-1:0] iIrq,
  input  logic             iMaskWr,
  input  logic [N_IRQ-1:0] iMaskData,
  output logic [31:0]      oPC,
  output logic [31:0]      oPCNext,
  output logic             oTakeIrq,
  output logic [CW-1:0]    oCause,
  output logic [31:0]      oEPC,
  output logic             oKernel,
  output logic [N_IRQ-1:0] oMask,
  output logic [N_IRQ-1:0] oPending
);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      epc_q, epc_d;
  logic [CW-1:0]    cause_q, cause_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] irq_q;

  logic [N_IRQ-1:0] eligible_s;
  logic [N_IRQ-1:0] clr_s;
  logic             valid_s;
  logic [CW-1:0]    idx_s;
  logic             take_s;
  logic [31:0]      vector_s;
  logic [31:0]      pc_next_s;

  assign eligible_s = pending_q & mask_q;

  irq_prio_enc #(.N(N_IRQ), .IW(CW)) u_prio (
    .req_i   (eligible_s),
    .valid_o (valid_s),
    .idx_o   (idx_s)
  );

  // No nesting: a channel is only taken from user mode on a non-stalled cycle.
  assign take_s   = ~pc_q[31] & ~iStall & valid_s;
  assign vector_s = VEC_BASE + ({{(32 - CW){1'b0}}, idx_s} * VEC_STRIDE);
  assign clr_s    = take_s ? (N_IRQ'(1) << idx_s) : '0;

  // Next-PC mux; a taken interrupt overrides the decoded select.
  always_comb begin
    pc_next_s = pc_q + 32'd4;
    if (take_s) begin
      pc_next_s = vector_s;
    end else begin
      case (iPCSel)
        PCSEL_PLUS4:  pc_next_s = pc_q + 32'd4;
        PCSEL_BRANCH: pc_next_s = keep_priv(iBranchTgt, pc_q[31]);
        PCSEL_JUMP:   pc_next_s = keep_priv(iJumpTgt, pc_q[31]);
        PCSEL_JR:     pc_next_s = iJRTgt;
        PCSEL_ERET:   pc_next_s = epc_q;
        default:      pc_next_s = pc_q + 32'd4;
      endcase
    end
  end

  // Next-state for architectural registers; a new edge beats the take-clear on pending.
  always_comb begin
    pc_d      = iStall ? pc_q : pc_next_s;
    epc_d     = take_s ? pc_q : epc_q;
    cause_d   = take_s ? idx_s : cause_q;
    mask_d    = iMaskWr ? iMaskData : mask_q;
    pending_d = (pending_q & ~clr_s) | (iIrq & ~irq_q);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      pc_q      <= RESET_PC;
      epc_q     <= 32'h0000_0000;
      cause_q   <= '0;
      mask_q    <= '1;
      pending_q <= '0;
      irq_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      irq_q     <= iIrq;
    end
  end

  assign oPC      = pc_q;
  assign oPCNext  = pc_next_s;
  assign oTakeIrq = take_s;
  assign oCause   = cause_q;
  assign oEPC     = epc_q;
  assign oKernel  = pc_q[31];
  assign oMask    = mask_q;
  assign oPending = pending_q;

endmodule

// File: tb/tb_pc_exc_unit.sv
// Directed scenarios plus a randomized run against a behavioural model of the PC/exception sequencer.
module tb_pc_exc_unit;

  localparam logic [31:0] VB = 32'h8000_0004;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iStall = 1'b0;
  logic [2:0]  iPCSel = 3'd0;
  logic [31:0] iBranchTgt = 32'h0, iJumpTgt = 32'h0, iJRTgt = 32'h0;
  logic [3:0]  iIrq = 4'h0;
  logic        iMaskWr = 1'b0;
  logic [3:0]  iMaskData = 4'h0;
  logic [31:0] oPC, oPCNext, oEPC;
  logic        oTakeIrq, oKernel;
  logic [1:0]  oCause;
  logic [3:0]  oMask, oPending;

  int total = 0;
  int bad = 0;

  pc_exc_unit dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStall(iStall), .iPCSel(iPCSel),
    .iBranchTgt(iBranchTgt), .iJumpTgt(iJumpTgt), .iJRTgt(iJRTgt),
    .iIrq(iIrq), .iMaskWr(iMaskWr), .iMaskData(iMaskData),
    .oPC(oPC), .oPCNext(oPCNext), .oTakeIrq(oTakeIrq), .oCause(oCause),
    .oEPC(oEPC), .oKernel(oKernel), .oMask(oMask), .oPending(oPending)
  );

  always #5 iClk = ~iClk;

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic apply_reset();
    iRst_n = 1'b0; iStall = 1'b0; iPCSel = 3'd0; iIrq = 4'h0; iMaskWr = 1'b0;
    @(negedge iClk);
    iRst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (oPC !== 32'h0040_0000) begin bad++; $display("FAIL reset_pc got=%h exp=%h", oPC, 32'h0040_0000); end
    total++; if (oMask !== 4'hF) begin bad++; $display("FAIL reset_mask got=%h exp=f", oMask); end
    total++; if (oPending !== 4'h0) begin bad++; $display("FAIL reset_pend got=%h exp=0", oPending); end
    total++; if (oEPC !== 32'h0) begin bad++; $display("FAIL reset_epc got=%h exp=0", oEPC); end
    total++; if (oCause !== 2'd0) begin bad++; $display("FAIL reset_cause got=%0d exp=0", oCause); end
    total++; if (oTakeIrq !== 1'b0) begin bad++; $display("FAIL reset_take got=%b exp=0", oTakeIrq); end
    for (int i = 1; i <= 4; i++) begin
      step();
      total++;
      if (oPC !== 32'h0040_0000 + 32'(i * 4)) begin
        bad++; $display("FAIL plus4_%0d got=%h exp=%h", i, oPC, 32'h0040_0000 + 32'(i * 4));
      end
    end
  endtask

  task automatic test_branch_jr();
    iPCSel = 3'd1; iBranchTgt = 32'h8040_0100;
    step();
    total++; if (oPC !== 32'h0040_0100) begin bad++; $display("FAIL branch_priv got=%h exp=00400100", oPC); end
    iPCSel = 3'd3; iJRTgt = 32'h8000_0000;
    step();
    total++; if (oPC !== 32'h8000_0000 || oKernel !== 1'b1) begin bad++; $display("FAIL jr_kernel got=%h k=%b exp=80000000 k=1", oPC, oKernel); end
    iPCSel = 3'd3; iJRTgt = 32'h0040_001C;
    step();
    total++; if (oPC !== 32'h0040_001C) begin bad++; $display("FAIL jr_user got=%h exp=0040001c", oPC); end
  endtask

  task automatic test_irq_basic();
    iPCSel = 3'd0; iIrq = 4'b0100;
    step();
    total++; if (oPC !== 32'h0040_0020 || oPending !== 4'b0100) begin bad++; $display("FAIL irq_pend pc=%h pend=%b exp 00400020 0100", oPC, oPending); end
    total++; if (oTakeIrq !== 1'b1 || oPCNext !== 32'h8000_0014) begin bad++; $display("FAIL irq_take take=%b next=%h exp 1 80000014", oTakeIrq, oPCNext); end
    step();
    total++; if (oPC !== 32'h8000_0014) begin bad++; $display("FAIL irq_vec got=%h exp=80000014", oPC); end
    total++; if (oEPC !== 32'h0040_0020) begin bad++; $display("FAIL irq_epc got=%h exp=00400020", oEPC); end
    total++; if (oCause !== 2'd2 || oPending !== 4'b0000) begin bad++; $display("FAIL irq_cause cause=%0d pend=%b exp 2 0000", oCause, oPending); end
  endtask

  task automatic test_priority_nest();
    iPCSel = 3'd4; iIrq = 4'b0000;
    step();
    total++; if (oPC !== 32'h0040_0020) begin bad++; $display("FAIL eret1 got=%h exp=00400020", oPC); end
    iPCSel = 3'd0; iIrq = 4'b1010;
    step();
    total++; if (oTakeIrq !== 1'b1 || oPCNext !== 32'h8000_000C) begin bad++; $display("FAIL prio_take take=%b next=%h exp 1 8000000c", oTakeIrq, oPCNext); end
    step();
    total++; if (oPC !== 32'h8000_000C || oCause !== 2'd1 || oPending !== 4'b1000) begin bad++; $display("FAIL prio_win pc=%h cause=%0d pend=%b", oPC, oCause, oPending); end
    total++; if (oTakeIrq !== 1'b0) begin bad++; $display("FAIL kernel_nonest got=%b exp=0", oTakeIrq); end
    iPCSel = 3'd2; iJumpTgt = 32'h0000_0040;
    step();
    total++; if (oPC !== 32'h8000_0040) begin bad++; $display("FAIL jump_priv got=%h exp=80000040", oPC); end
    iPCSel = 3'd4;
    step();
    total++; if (oPC !== 32'h0040_0024) begin bad++; $display("FAIL eret2 got=%h exp=00400024", oPC); end
    iPCSel = 3'd0;
    #1;
    total++; if (oTakeIrq !== 1'b1 || oPCNext !== 32'h8000_001C) begin bad++; $display("FAIL ch3_take take=%b next=%h", oTakeIrq, oPCNext); end
    step();
    total++; if (oPC !== 32'h8000_001C || oCause !== 2'd3 || oPending !== 4'b0000) begin bad++; $display("FAIL ch3_vec pc=%h cause=%0d pend=%b", oPC, oCause, oPending); end
    iPCSel = 3'd4; iIrq = 4'b0000;
    step();
  endtask

  task automatic test_mask();
    iPCSel = 3'd0; iMaskWr = 1'b1; iMaskData = 4'hE;
    step();
    total++; if (oMask !== 4'hE) begin bad++; $display("FAIL mask_wr got=%h exp=e", oMask); end
    iMaskWr = 1'b0; iIrq = 4'b0001;
    step();
    total++; if (oPending !== 4'b0001 || oTakeIrq !== 1'b0) begin bad++; $display("FAIL mask_block pend=%b take=%b", oPending, oTakeIrq); end
    iMaskWr = 1'b1; iMaskData = 4'hF;
    #1;
    total++; if (oTakeIrq !== 1'b0) begin bad++; $display("FAIL mask_old got=%b exp=0", oTakeIrq); end
    step();
    iMaskWr = 1'b0;
    #1;
    total++; if (oTakeIrq !== 1'b1 || oPCNext !== VB) begin bad++; $display("FAIL mask_take take=%b next=%h", oTakeIrq, oPCNext); end
    step();
    total++; if (oPC !== VB || oEPC !== 32'h0040_0030) begin bad++; $display("FAIL mask_vec pc=%h epc=%h", oPC, oEPC); end
  endtask

  task automatic test_stall_reset();
    iPCSel = 3'd4; iIrq = 4'b0000;
    step();
    iPCSel = 3'd0; iStall = 1'b1; iIrq = 4'b0010;
    step();
    total++; if (oPC !== 32'h0040_0030 || oPending !== 4'b0010) begin bad++; $display("FAIL stall_hold pc=%h pend=%b", oPC, oPending); end
    total++; if (oTakeIrq !== 1'b0) begin bad++; $display("FAIL stall_notake got=%b exp=0", oTakeIrq); end
    step();
    total++; if (oPC !== 32'h0040_0030) begin bad++; $display("FAIL stall_hold2 got=%h", oPC); end
    iStall = 1'b0;
    #1;
    total++; if (oTakeIrq !== 1'b1) begin bad++; $display("FAIL unstall_take got=%b exp=1", oTakeIrq); end
    step();
    total++; if (oPC !== 32'h8000_000C) begin bad++; $display("FAIL unstall_vec got=%h", oPC); end
    iIrq = 4'b1010;
    step();
    iRst_n = 1'b0;
    #1;
    total++; if (oPending !== 4'h0 || oPC !== 32'h0040_0000) begin bad++; $display("FAIL async_rst pend=%b pc=%h", oPending, oPC); end
    iIrq = 4'b0000;
    @(negedge iClk);
    iRst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] m_pc, m_epc, exp_next, br, jp, jr;
    logic [3:0]  m_mask, m_pend, m_prev, irq, mdat;
    int          m_cause, win;
    logic        stall, mwr, take;
    logic [2:0]  sel;
    apply_reset();
    m_pc = 32'h0040_0000; m_epc = 32'h0; m_mask = 4'hF; m_pend = 4'h0; m_prev = 4'h0; m_cause = 0;
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 4) == 0);
      sel   = 3'($urandom_range(0, 7));
      br    = $urandom; jp = $urandom; jr = $urandom;
      irq   = 4'($urandom);
      mwr   = ($urandom_range(0, 6) == 0);
      mdat  = 4'($urandom);
      if (c == 50) begin jr = 32'hFFFF_FFFC; sel = 3'd3; stall = 1'b0; end
      iStall = stall; iPCSel = sel; iBranchTgt = br; iJumpTgt = jp; iJRTgt = jr;
      iIrq = irq; iMaskWr = mwr; iMaskData = mdat;
      win = -1;
      for (int i = 0; i < 4; i++) if (win < 0 && m_pend[i] && m_mask[i]) win = i;
      take = (m_pc[31] == 1'b0) && !stall && (win >= 0);
      if (take) exp_next = VB + 32'(win * 8);
      else if (sel == 3'd1) exp_next = {m_pc[31], br[30:0]};
      else if (sel == 3'd2) exp_next = {m_pc[31], jp[30:0]};
      else if (sel == 3'd3) exp_next = jr;
      else if (sel == 3'd4) exp_next = m_epc;
      else exp_next = m_pc + 32'd4;
      #1;
      total++; if (oTakeIrq !== take) begin bad++; $display("FAIL rnd_take c=%0d got=%b exp=%b", c, oTakeIrq, take); end
      total++; if (oPCNext !== exp_next) begin bad++; $display("FAIL rnd_next c=%0d got=%h exp=%h", c, oPCNext, exp_next); end
      if (take) begin m_epc = m_pc; m_cause = win; m_pend[win] = 1'b0; end
      if (!stall) m_pc = exp_next;
      m_pend = m_pend | (irq & ~m_prev);
      m_prev = irq;
      if (mwr) m_mask = mdat;
      step();
      total++; if (oPC !== m_pc || oKernel !== m_pc[31]) begin bad++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, oPC, m_pc); end
      total++; if (oEPC !== m_epc || oCause !== 2'(m_cause)) begin bad++; $display("FAIL rnd_epc c=%0d epc=%h/%h cause=%0d/%0d", c, oEPC, m_epc, oCause, m_cause); end
      total++; if (oPending !== m_pend || oMask !== m_mask) begin bad++; $display("FAIL rnd_regs c=%0d pend=%b/%b mask=%b/%b", c, oPending, m_pend, oMask, m_mask); end
    end
  endtask

  initial begin
    test_reset();
    test_branch_jr();
    test_irq_basic();
    test_priority_nest();
    test_mask();
    test_stall_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
